// File: rtl/dcache_pkg.sv
// dcache_pkg -- shared definitions for the direct-mapped data cache.
//   * Controller state enumeration (IDLE, WRITEBACK, FETCH, UPDATE)
//   * Address / block / byte width constants
//   * select_byte(): pulls one byte lane out of a 32-bit block
// Optional feature macro used by the cache: DCACHE_STATS_EN (hit/miss counters).
package dcache_pkg;

    localparam int ADDR_W       = 8;   // CPU byte address width
    localparam int BLOCK_ADDR_W = 6;   // main-memory block address width
    localparam int OFFSET_W     = 2;   // byte offset inside a 4-byte block
    localparam int BYTE_W       = 8;
    localparam int WORD_W       = 32;  // block size in bits
    localparam int STAT_W       = 16;  // width of the optional counters

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        WRITEBACK = 2'd1,
        FETCH     = 2'd2,
        UPDATE    = 2'd3
    } state_t;

    // Byte k of a block lives in bits [8k+7:8k].
    function automatic logic [BYTE_W-1:0] select_byte(
        input logic [WORD_W-1:0]   block,
        input logic [OFFSET_W-1:0] offset
    );
        return block[offset*BYTE_W +: BYTE_W];
    endfunction

endpackage

// File: rtl/dcache_array.sv
// dcache_array -- valid/dirty/tag/data storage for the direct-mapped cache.
// Ports:
//   clk, rst         clock, asynchronous active-high reset (clears valid/dirty)
//   rd_index         block selected for the combinational read port
//   rd_valid/dirty   status bits of the selected block
//   rd_tag/rd_data   stored tag and 32-bit block of the selected block
//   byte_we/...      byte write port (CPU write hit): stores one byte, sets dirty
//   fill_we/...      block fill port (miss completion): data+tag, valid=1, dirty=0
// Tag and data arrays carry no reset; only valid/dirty need clearing.
module dcache_array
    import dcache_pkg::*;
#(
    parameter int INDEX_W = 3
) (
    input  logic                            clk,
    input  logic                            rst,
    input  logic [INDEX_W-1:0]              rd_index,
    output logic                            rd_valid,
    output logic                            rd_dirty,
    output logic [BLOCK_ADDR_W-INDEX_W-1:0] rd_tag,
    output logic [WORD_W-1:0]               rd_data,
    input  logic                            byte_we,
    input  logic [INDEX_W-1:0]              byte_index,
    input  logic [OFFSET_W-1:0]             byte_offset,
    input  logic [BYTE_W-1:0]               byte_data,
    input  logic                            fill_we,
    input  logic [INDEX_W-1:0]              fill_index,
    input  logic [BLOCK_ADDR_W-INDEX_W-1:0] fill_tag,
    input  logic [WORD_W-1:0]               fill_data
);

    localparam int TAG_W      = BLOCK_ADDR_W - INDEX_W;
    localparam int NUM_BLOCKS = 2 ** INDEX_W;

    logic [TAG_W-1:0]      tag_mem  [NUM_BLOCKS];
    logic [WORD_W-1:0]     data_mem [NUM_BLOCKS];
    logic [NUM_BLOCKS-1:0] valid_vec;
    logic [NUM_BLOCKS-1:0] dirty_vec;

    // One status flop pair per block so the async clear is a plain flop reset.
    genvar gi;
    generate
        for (gi = 0; gi < NUM_BLOCKS; gi++) begin : g_block
            logic valid_reg;
            logic dirty_reg;

            always_ff @(posedge clk or posedge rst) begin
                if (rst) begin
                    valid_reg <= 1'b0;
                    dirty_reg <= 1'b0;
                end else if (fill_we && (fill_index == INDEX_W'(gi))) begin
                    valid_reg <= 1'b1;
                    dirty_reg <= 1'b0;
                end else if (byte_we && (byte_index == INDEX_W'(gi))) begin
                    dirty_reg <= 1'b1;
                end
            end

            assign valid_vec[gi] = valid_reg;
            assign dirty_vec[gi] = dirty_reg;
        end
    endgenerate

    always_ff @(posedge clk) begin
        if (fill_we) begin
            data_mem[fill_index] <= fill_data;
            tag_mem[fill_index]  <= fill_tag;
        end else if (byte_we) begin
            data_mem[byte_index][byte_offset*BYTE_W +: BYTE_W] <= byte_data;
        end
    end

    assign rd_valid = valid_vec[rd_index];
    assign rd_dirty = dirty_vec[rd_index];
    assign rd_tag   = tag_mem[rd_index];
    assign rd_data  = data_mem[rd_index];

endmodule

// File: rtl/dcache.sv
// dcache -- direct-mapped, write-back, write-allocate byte-wide data cache.
// Ports:
//   CLK, RESET            clock, asynchronous active-high reset
//   READ, WRITE           CPU requests (both high = write), held while BUSYWAIT
//   ADDRESS               {tag, index, offset} byte address
//   WRITEDATA, READDATA   CPU byte in / out (READDATA is 0 unless read hit)
//   BUSYWAIT              CPU stall
//   MEM_READ, MEM_WRITE   main-memory strobes, held until MEM_BUSYWAIT is low
//   MEM_ADDRESS           block address
//   MEM_WRITEDATA         victim block during write-back
//   MEM_READDATA          fetched block
//   MEM_BUSYWAIT          memory stall
//   HIT_COUNT, MISS_COUNT saturating counters, only with DCACHE_STATS_EN defined
module dcache
    import dcache_pkg::*;
#(
    parameter int INDEX_W = 3
) (
    input  logic                    CLK,
    input  logic                    RESET,
    input  logic                    READ,
    input  logic                    WRITE,
    input  logic [ADDR_W-1:0]       ADDRESS,
    input  logic [BYTE_W-1:0]       WRITEDATA,
    output logic [BYTE_W-1:0]       READDATA,
    output logic                    BUSYWAIT,
    output logic                    MEM_READ,
    output logic                    MEM_WRITE,
    output logic [BLOCK_ADDR_W-1:0] MEM_ADDRESS,
    output logic [WORD_W-1:0]       MEM_WRITEDATA,
    input  logic [WORD_W-1:0]       MEM_READDATA,
    input  logic                    MEM_BUSYWAIT
`ifdef DCACHE_STATS_EN
    ,
    output logic [STAT_W-1:0]       HIT_COUNT,
    output logic [STAT_W-1:0]       MISS_COUNT
`endif
);

    localparam int TAG_W = BLOCK_ADDR_W - INDEX_W;

    state_t              state_reg, state_next;
    logic [WORD_W-1:0]   fetch_data_reg;

    logic [TAG_W-1:0]    addr_tag;
    logic [INDEX_W-1:0]  addr_index;
    logic [OFFSET_W-1:0] addr_offset;

    logic                blk_valid, blk_dirty;
    logic [TAG_W-1:0]    blk_tag;
    logic [WORD_W-1:0]   blk_data;

    logic req, hit, read_only, byte_we, fill_we, fetch_done;

    assign addr_tag    = ADDRESS[ADDR_W-1:OFFSET_W+INDEX_W];
    assign addr_index  = ADDRESS[OFFSET_W+INDEX_W-1:OFFSET_W];
    assign addr_offset = ADDRESS[OFFSET_W-1:0];

    assign req       = READ | WRITE;
    assign read_only = READ & ~WRITE;
    assign hit       = blk_valid & (blk_tag == addr_tag);

    assign byte_we    = (state_reg == IDLE) & WRITE & hit;
    assign fill_we    = (state_reg == UPDATE);
    assign fetch_done = (state_reg == FETCH) & ~MEM_BUSYWAIT;

    dcache_array #(.INDEX_W(INDEX_W)) u_array (
        .clk        (CLK),
        .rst        (RESET),
        .rd_index   (addr_index),
        .rd_valid   (blk_valid),
        .rd_dirty   (blk_dirty),
        .rd_tag     (blk_tag),
        .rd_data    (blk_data),
        .byte_we    (byte_we),
        .byte_index (addr_index),
        .byte_offset(addr_offset),
        .byte_data  (WRITEDATA),
        .fill_we    (fill_we),
        .fill_index (addr_index),
        .fill_tag   (addr_tag),
        .fill_data  (fetch_data_reg)
    );

    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            state_reg      <= IDLE;
            fetch_data_reg <= '0;
        end else begin
            state_reg <= state_next;
            if (fetch_done) begin
                fetch_data_reg <= MEM_READDATA;
            end
        end
    end

    always_comb begin
        state_next    = state_reg;
        MEM_READ      = 1'b0;
        MEM_WRITE     = 1'b0;
        MEM_ADDRESS   = '0;
        MEM_WRITEDATA = '0;
        case (state_reg)
            IDLE: begin
                if (req && !hit) begin
                    state_next = (blk_valid && blk_dirty) ? WRITEBACK : FETCH;
                end
            end
            WRITEBACK: begin
                // Victim address comes from the stored tag, not the CPU tag.
                MEM_WRITE     = 1'b1;
                MEM_ADDRESS   = {blk_tag, addr_index};
                MEM_WRITEDATA = blk_data;
                if (!MEM_BUSYWAIT) begin
                    state_next = FETCH;
                end
            end
            FETCH: begin
                MEM_READ    = 1'b1;
                MEM_ADDRESS = ADDRESS[ADDR_W-1:OFFSET_W];
                if (!MEM_BUSYWAIT) begin
                    state_next = UPDATE;
                end
            end
            UPDATE: begin
                state_next = IDLE;
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    // BUSYWAIT is forced low while RESET is high so the CPU sees the
    // abandoned miss released immediately, even with its request still up.
    assign BUSYWAIT = ~RESET & ((state_reg != IDLE) | (req & ~hit));
    assign READDATA = ((state_reg == IDLE) && read_only && hit)
                      ? select_byte(blk_data, addr_offset) : '0;

`ifdef DCACHE_STATS_EN
    logic [STAT_W-1:0] hit_count_reg, miss_count_reg;
    // High for the first IDLE cycle after a fill: that hit finishes a miss
    // already counted, so it is not counted again as a hit.
    logic              completing_reg;

    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            hit_count_reg  <= '0;
            miss_count_reg <= '0;
            completing_reg <= 1'b0;
        end else begin
            completing_reg <= (state_reg == UPDATE);
            if ((state_reg == IDLE) && req) begin
                if (hit && !completing_reg && (hit_count_reg != {STAT_W{1'b1}})) begin
                    hit_count_reg <= hit_count_reg + 1'b1;
                end
                if (!hit && (miss_count_reg != {STAT_W{1'b1}})) begin
                    miss_count_reg <= miss_count_reg + 1'b1;
                end
            end
        end
    end

    assign HIT_COUNT  = hit_count_reg;
    assign MISS_COUNT = miss_count_reg;
`endif

endmodule

// File: tb/tb_dcache.sv
// tb_dcache -- directed, table-driven self-checking bench for dcache.
// A small behavioural main memory (fixed 3-cycle strobe latency, optional
// indefinite stall via 'hold') answers the cache. Fresh memory holds byte
// value == byte address, except blocks 0x01 and 0x09 which are preloaded.
module tb_dcache;

    logic        clk = 1'b0;
    logic        reset;
    logic        read, write;
    logic [7:0]  address, writedata, readdata;
    logic        busywait;
    logic        mem_read, mem_write;
    logic [5:0]  mem_address;
    logic [31:0] mem_writedata, mem_readdata;
    logic        mem_busywait;
`ifdef DCACHE_STATS_EN
    logic [15:0] hit_count, miss_count;
`endif

    int checks = 0;
    int errors = 0;

    dcache #(.INDEX_W(3)) dut (
        .CLK          (clk),
        .RESET        (reset),
        .READ         (read),
        .WRITE        (write),
        .ADDRESS      (address),
        .WRITEDATA    (writedata),
        .READDATA     (readdata),
        .BUSYWAIT     (busywait),
        .MEM_READ     (mem_read),
        .MEM_WRITE    (mem_write),
        .MEM_ADDRESS  (mem_address),
        .MEM_WRITEDATA(mem_writedata),
        .MEM_READDATA (mem_readdata),
        .MEM_BUSYWAIT (mem_busywait)
`ifdef DCACHE_STATS_EN
        ,
        .HIT_COUNT    (hit_count),
        .MISS_COUNT   (miss_count)
`endif
    );

    always #5 clk = ~clk;

    // ---------------- behavioural main memory ----------------
    logic [31:0] mem [64];
    int          mcnt = 0;
    bit          hold = 1'b0;
    bit          mem_load = 1'b0;

    assign mem_busywait = (mem_read | mem_write) & (hold | (mcnt < 2));
    assign mem_readdata = mem[mem_address];

    always @(posedge clk) begin
        if (mem_load) begin
            for (int k = 0; k < 64; k++) begin
                if (k == 1)      mem[k] <= 32'h44332211;
                else if (k == 9) mem[k] <= 32'h88776655;
                else mem[k] <= {8'(4*k+3), 8'(4*k+2), 8'(4*k+1), 8'(4*k)};
            end
            mcnt <= 0;
        end else if ((mem_read | mem_write) && !mem_busywait) begin
            if (mem_write) mem[mem_address] <= mem_writedata;
            mcnt <= 0;
        end else if (mem_read | mem_write) begin
            mcnt <= mcnt + 1;
        end else begin
            mcnt <= 0;
        end
    end

    // ---------------- helpers ----------------
    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Drive one CPU request and hold it until BUSYWAIT is low; returns the
    // byte seen in the accepting cycle and the number of cycles it took.
    task automatic access(input logic rd, input logic wr, input logic [7:0] a,
                          input logic [7:0] wd, output logic [7:0] rdata,
                          output int cyc, output bit timeout);
        read = rd; write = wr; address = a; writedata = wd;
        cyc = 0; timeout = 1'b1; rdata = 8'h00;
        for (int k = 0; k < 40; k++) begin
            @(negedge clk);
            cyc++;
            if (!busywait) begin
                rdata   = readdata;
                timeout = 1'b0;
                break;
            end
            @(posedge clk);
            #1;
        end
        @(posedge clk);
        #1;
        read = 1'b0; write = 1'b0;
    endtask

    typedef struct {
        logic       rd;
        logic       wr;
        logic [7:0] addr;
        logic [7:0] wdata;
        logic [7:0] exp_rdata;
        int         exp_cycles;
    } vec_t;

    vec_t        vecs [11];
    logic [7:0]  got;
    int          cyc;
    bit          to;

    initial begin
        // clean miss = 1 detect + 3 FETCH + 1 UPDATE + 1 hit = 6
        // dirty miss adds 3 WRITEBACK cycles = 9
        vecs[0]  = '{1'b1, 1'b0, 8'h05, 8'h00, 8'h22, 6};  // clean miss, block 1
        vecs[1]  = '{1'b0, 1'b1, 8'h06, 8'hAB, 8'h00, 1};  // write hit
        vecs[2]  = '{1'b1, 1'b0, 8'h06, 8'h00, 8'hAB, 1};  // read back
        vecs[3]  = '{1'b1, 1'b0, 8'h25, 8'h00, 8'h66, 9};  // dirty miss, block 9
        vecs[4]  = '{1'b1, 1'b1, 8'h27, 8'h5A, 8'h00, 1};  // both high = write
        vecs[5]  = '{1'b1, 1'b0, 8'h27, 8'h00, 8'h5A, 1};
        vecs[6]  = '{1'b1, 1'b0, 8'h44, 8'h00, 8'h44, 9};  // evicts dirty block 9
        vecs[7]  = '{1'b0, 1'b1, 8'h80, 8'h11, 8'h00, 6};  // write miss, allocate
        vecs[8]  = '{1'b1, 1'b0, 8'h80, 8'h00, 8'h11, 1};
        vecs[9]  = '{1'b1, 1'b0, 8'h81, 8'h00, 8'h81, 1};
        vecs[10] = '{1'b1, 1'b0, 8'h00, 8'h00, 8'h00, 9};  // evicts dirty block 0x20

        reset = 1'b0; read = 1'b0; write = 1'b0; address = 8'h00; writedata = 8'h00;
        mem_load = 1'b1;
        #1 reset = 1'b1;
        #2;
        check("reset_busywait", 32'(busywait), 32'h0);
        check("reset_mem_read", 32'(mem_read), 32'h0);
        check("reset_mem_write", 32'(mem_write), 32'h0);
        check("reset_mem_address", 32'(mem_address), 32'h0);
        check("reset_mem_writedata", mem_writedata, 32'h0);
        check("reset_readdata", 32'(readdata), 32'h0);
`ifdef DCACHE_STATS_EN
        check("reset_hit_count", 32'(hit_count), 32'h0);
        check("reset_miss_count", 32'(miss_count), 32'h0);
`endif
        @(posedge clk); #1 mem_load = 1'b0;
        @(posedge clk); #1 reset = 1'b0;

        for (int i = 0; i < 11; i++) begin
            access(vecs[i].rd, vecs[i].wr, vecs[i].addr, vecs[i].wdata, got, cyc, to);
            $display("txn %0d: rd=%0b wr=%0b addr=%02h wdata=%02h readdata=%02h cycles=%0d",
                     i, vecs[i].rd, vecs[i].wr, vecs[i].addr, vecs[i].wdata, got, cyc);
            check($sformatf("txn%0d_timeout", i), 32'(to), 32'h0);
            check($sformatf("txn%0d_readdata", i), 32'(got), 32'(vecs[i].exp_rdata));
            check($sformatf("txn%0d_cycles", i), 32'(cyc), 32'(vecs[i].exp_cycles));
`ifdef DCACHE_STATS_EN
            if (i == 3) begin
                check("stats_hit_after_3", 32'(hit_count), 32'd2);
                check("stats_miss_after_3", 32'(miss_count), 32'd2);
            end
`endif
        end

        // Write-backs must have landed at the victim's own block address.
        check("wb_block01", mem[1], 32'h44AB2211);
        check("wb_block09", mem[9], 32'h5A776655);
        check("wb_block20", mem[32], 32'h83828111);
`ifdef DCACHE_STATS_EN
        check("stats_hit_total", 32'(hit_count), 32'd6);
        check("stats_miss_total", 32'(miss_count), 32'd5);
`endif

        // Dirty a block, then abandon a stalled fetch with a reset pulse.
        access(1'b0, 1'b1, 8'h05, 8'h77, got, cyc, to);
        $display("txn dirty: wr addr=05 wdata=77 cycles=%0d", cyc);
        check("dirty_write_cycles", 32'(cyc), 32'd6);

        hold = 1'b1;
        read = 1'b1; address = 8'h09;
        @(posedge clk); #1;
        check("fetch_mem_read", 32'(mem_read), 32'h1);
        check("fetch_mem_write", 32'(mem_write), 32'h0);
        check("fetch_mem_address", 32'(mem_address), 32'h02);
        check("fetch_busywait", 32'(busywait), 32'h1);
        @(posedge clk); #1;
        check("fetch_hold_mem_read", 32'(mem_read), 32'h1);
        check("fetch_hold_mem_address", 32'(mem_address), 32'h02);
        #2 reset = 1'b1;
        #1;
        $display("txn reset mid-fetch: mem_read=%0b busywait=%0b", mem_read, busywait);
        check("midreset_mem_read", 32'(mem_read), 32'h0);
        check("midreset_busywait", 32'(busywait), 32'h0);
        check("midreset_mem_address", 32'(mem_address), 32'h0);
`ifdef DCACHE_STATS_EN
        check("midreset_hit_count", 32'(hit_count), 32'h0);
        check("midreset_miss_count", 32'(miss_count), 32'h0);
`endif
        @(posedge clk); #1;
        reset = 1'b0; read = 1'b0; hold = 1'b0;
        @(posedge clk); #1;

        // Dirty byte 0x77 was lost: a clean miss refetches the memory copy.
        access(1'b1, 1'b0, 8'h05, 8'h00, got, cyc, to);
        $display("txn after reset: rd addr=05 readdata=%02h cycles=%0d", got, cyc);
        check("post_reset_timeout", 32'(to), 32'h0);
        check("post_reset_readdata", 32'(got), 32'h22);
        check("post_reset_cycles", 32'(cyc), 32'd6);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
